// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the imem request handshake and loads IF/ID.
// Redirects on EX control transfers, squashes wrong-path work, and parks a word in a skid entry on hold.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bran_stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic [31:0] ex_pc,
    input  logic        hold_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        id_flush,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DROP  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_stale_addr, w_stale_addr_nxt;
    logic [31:0] r_skid_pc, w_skid_pc_nxt;
    logic [31:0] r_skid_instr, w_skid_instr_nxt;
    logic [31:0] r_if_id_pc, w_if_id_pc_nxt;
    logic [31:0] r_if_id_instr, w_if_id_instr_nxt;
    logic        r_if_id_valid, w_if_id_valid_nxt;
    logic [31:0] w_raw_target;
    logic [31:0] w_redirect;

    assign w_raw_target = br_taken ? br_target : (ex_pc + 32'd4);
    assign w_redirect   = w_raw_target & 32'hFFFF_FFFC;

    // Handshake: a word transfers in any cycle with imem_req && imem_ready; once
    // imem_req is high without imem_ready, imem_req/imem_addr hold until imem_ready.
    // DROP keeps presenting the abandoned address so that rule survives a redirect.
    assign imem_req  = (r_state == ST_FETCH) || (r_state == ST_DROP);
    assign imem_addr = ((r_state == ST_DROP) ? r_stale_addr : r_pc) & 32'hFFFF_FFFC;
    assign id_flush  = bran_stall & rst_n;
    assign dbg_state = r_state;

    assign if_id_pc    = r_if_id_pc;
    assign if_id_instr = r_if_id_instr;
    assign if_id_valid = r_if_id_valid;

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_stale_addr_nxt  = r_stale_addr;
        w_skid_pc_nxt     = r_skid_pc;
        w_skid_instr_nxt  = r_skid_instr;
        w_if_id_pc_nxt    = r_if_id_pc;
        w_if_id_instr_nxt = r_if_id_instr;
        w_if_id_valid_nxt = r_if_id_valid;
        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_FETCH;
                if (bran_stall) w_pc_nxt = w_redirect;
            end
            ST_FETCH: begin
                if (bran_stall) begin
                    w_pc_nxt          = w_redirect;
                    w_if_id_pc_nxt    = 32'd0;
                    w_if_id_instr_nxt = NOP_INSTR;
                    w_if_id_valid_nxt = 1'b0;
                    if (!imem_ready) begin
                        w_stale_addr_nxt = imem_addr;
                        w_state_nxt      = ST_DROP;
                    end
                end else if (hold_stall) begin
                    if (imem_ready) begin
                        w_skid_pc_nxt    = r_pc;
                        w_skid_instr_nxt = imem_rdata;
                        w_pc_nxt         = r_pc + 32'd4;
                        w_state_nxt      = ST_HOLD;
                    end
                end else if (imem_ready) begin
                    w_if_id_pc_nxt    = r_pc;
                    w_if_id_instr_nxt = imem_rdata;
                    w_if_id_valid_nxt = 1'b1;
                    w_pc_nxt          = r_pc + 32'd4;
                end else begin
                    w_if_id_pc_nxt    = 32'd0;
                    w_if_id_instr_nxt = NOP_INSTR;
                    w_if_id_valid_nxt = 1'b0;
                end
            end
            ST_DROP: begin
                // The returning word belongs to the abandoned path and is never used.
                if (bran_stall) w_pc_nxt = w_redirect;
                if (bran_stall || !hold_stall) begin
                    w_if_id_pc_nxt    = 32'd0;
                    w_if_id_instr_nxt = NOP_INSTR;
                    w_if_id_valid_nxt = 1'b0;
                end
                if (imem_ready) w_state_nxt = ST_FETCH;
            end
            ST_HOLD: begin
                if (bran_stall) begin
                    w_pc_nxt          = w_redirect;
                    w_if_id_pc_nxt    = 32'd0;
                    w_if_id_instr_nxt = NOP_INSTR;
                    w_if_id_valid_nxt = 1'b0;
                    w_state_nxt       = ST_FETCH;
                end else if (!hold_stall) begin
                    w_if_id_pc_nxt    = r_skid_pc;
                    w_if_id_instr_nxt = r_skid_instr;
                    w_if_id_valid_nxt = 1'b1;
                    w_state_nxt       = ST_FETCH;
                end
            end
            default: w_state_nxt = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_BOOT;
            r_pc          <= RESET_PC;
            r_stale_addr  <= 32'd0;
            r_skid_pc     <= 32'd0;
            r_skid_instr  <= 32'd0;
            r_if_id_pc    <= 32'd0;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_stale_addr  <= w_stale_addr_nxt;
            r_skid_pc     <= w_skid_pc_nxt;
            r_skid_instr  <= w_skid_instr_nxt;
            r_if_id_pc    <= w_if_id_pc_nxt;
            r_if_id_instr <= w_if_id_instr_nxt;
            r_if_id_valid <= w_if_id_valid_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run
// against a flag-based behavioural model of the fetch rules.
module tb_fetch_stage;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] TAG    = 32'h5A00_0000;
    localparam logic [1:0]  S_BOOT = 2'd0;
    localparam logic [1:0]  S_DROP = 2'd2;
    localparam logic [1:0]  S_HOLD = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bran_stall = 1'b0, br_taken = 1'b0, hold_stall = 1'b0, imem_ready = 1'b0;
    logic [31:0] br_target = '0, ex_pc = '0, imem_rdata = '0;
    logic        imem_req, if_id_valid, id_flush;
    logic [31:0] imem_addr, if_id_pc, if_id_instr;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_bad = 0;
    bit rand_data = 1'b0;

    // Model: pc, abandoned-request flag/address, skid flag/contents, boot flag, IF/ID image.
    logic [31:0] m_pc, m_stale, m_skid_pc, m_skid_instr, m_if_pc, m_if_instr;
    bit          m_boot, m_stale_pend, m_skid_full, m_if_valid;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .bran_stall(bran_stall), .br_taken(br_taken),
        .br_target(br_target), .ex_pc(ex_pc), .hold_stall(hold_stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
        .if_id_valid(if_id_valid), .id_flush(id_flush), .dbg_state(dbg_state)
    );

    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ TAG;
    endfunction

    // Drive one cycle's inputs just after the edge, return at the sampling point.
    task automatic cyc(input bit b, input bit bt, input logic [31:0] tgt,
                       input logic [31:0] expc, input bit h, input bit r);
        @(posedge clk); #1;
        bran_stall = b; br_taken = bt; br_target = tgt; ex_pc = expc;
        hold_stall = h; imem_ready = r;
        if (!r) imem_rdata = 32'hDEAD_BEEF;
        else if (rand_data) imem_rdata = $urandom;
        else imem_rdata = tag(imem_addr);
        @(negedge clk);
    endtask

    task automatic idle(input bit r);
        cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, r);
    endtask

    task automatic do_release;
        @(posedge clk); #1;
        rst_n = 1'b1; bran_stall = 1'b0; hold_stall = 1'b0; imem_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic apply_reset;
        @(negedge clk);
        rst_n = 1'b0; bran_stall = 1'b0; hold_stall = 1'b0; imem_ready = 1'b0;
        @(negedge clk);
        do_release();
    endtask

    task automatic model_reset;
        m_pc = 32'd0; m_stale = 32'd0; m_skid_pc = 32'd0; m_skid_instr = 32'd0;
        m_boot = 1'b1; m_stale_pend = 1'b0; m_skid_full = 1'b0;
        m_if_pc = 32'd0; m_if_instr = NOP; m_if_valid = 1'b0;
    endtask

    task automatic model_bubble;
        m_if_pc = 32'd0; m_if_instr = NOP; m_if_valid = 1'b0;
    endtask

    task automatic model_step(input bit b, input bit bt, input logic [31:0] tgt,
                              input logic [31:0] expc, input bit h, input bit r,
                              input logic [31:0] rd);
        logic [31:0] redir;
        redir = (bt ? tgt : expc + 32'd4) & 32'hFFFF_FFFC;
        if (m_boot) begin
            m_boot = 1'b0;
            if (b) m_pc = redir;
        end else if (m_skid_full) begin
            if (b) begin
                m_skid_full = 1'b0; m_pc = redir; model_bubble();
            end else if (!h) begin
                m_if_pc = m_skid_pc; m_if_instr = m_skid_instr; m_if_valid = 1'b1;
                m_skid_full = 1'b0;
            end
        end else if (m_stale_pend) begin
            if (b) m_pc = redir;
            if (b || !h) model_bubble();
            if (r) m_stale_pend = 1'b0;
        end else if (b) begin
            if (!r) begin m_stale = m_pc; m_stale_pend = 1'b1; end
            m_pc = redir; model_bubble();
        end else if (h) begin
            if (r) begin
                m_skid_full = 1'b1; m_skid_pc = m_pc; m_skid_instr = rd; m_pc = m_pc + 32'd4;
            end
        end else if (r) begin
            m_if_pc = m_pc; m_if_instr = rd; m_if_valid = 1'b1; m_pc = m_pc + 32'd4;
        end else begin
            model_bubble();
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; bran_stall = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
        n_cmp++; if ({if_id_pc, if_id_instr, if_id_valid} !== {32'd0, NOP, 1'b0}) begin n_bad++;
            $display("FAIL reset_ifid: got %h/%h/%b want 0/%h/0", if_id_pc, if_id_instr, if_id_valid, NOP); end
        n_cmp++; if (id_flush !== 1'b0) begin n_bad++; $display("FAIL reset_flush: got %b want 0", id_flush); end
        n_cmp++; if (dbg_state !== S_BOOT) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", dbg_state, S_BOOT); end
        do_release();
        n_cmp++; if ({imem_req, dbg_state} !== {1'b0, S_BOOT}) begin n_bad++;
            $display("FAIL boot_cycle: got req=%b st=%0d want req=0 st=0", imem_req, dbg_state); end
    endtask

    task automatic test_startup;
        idle(1'b1);
        n_cmp++; if ({imem_req, imem_addr} !== {1'b1, 32'd0}) begin n_bad++;
            $display("FAIL first_req: got %b/%h want 1/0", imem_req, imem_addr); end
        n_cmp++; if (if_id_valid !== 1'b0) begin n_bad++; $display("FAIL first_valid_early: got %b want 0", if_id_valid); end
        for (int k = 0; k < 6; k++) begin
            idle(1'b1);
            n_cmp++; if ({imem_req, imem_addr} !== {1'b1, 32'(4 * (k + 1))}) begin n_bad++;
                $display("FAIL seq_addr%0d: got %b/%h want 1/%h", k, imem_req, imem_addr, 32'(4 * (k + 1))); end
            n_cmp++; if ({if_id_pc, if_id_instr, if_id_valid} !== {32'(4 * k), tag(32'(4 * k)), 1'b1}) begin n_bad++;
                $display("FAIL seq_ifid%0d: got %h/%h/%b want %h/%h/1", k, if_id_pc, if_id_instr, if_id_valid,
                         32'(4 * k), tag(32'(4 * k))); end
        end
    endtask

    task automatic test_taken_branch;
        cyc(1'b1, 1'b1, 32'h100, 32'd0, 1'b0, 1'b1);
        n_cmp++; if (id_flush !== 1'b1) begin n_bad++; $display("FAIL taken_flush: got %b want 1", id_flush); end
        idle(1'b1);
        n_cmp++; if ({id_flush, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h100}) begin n_bad++;
            $display("FAIL taken_req: got fl=%b %b/%h want 0 1/100", id_flush, imem_req, imem_addr); end
        n_cmp++; if ({if_id_pc, if_id_instr, if_id_valid} !== {32'd0, NOP, 1'b0}) begin n_bad++;
            $display("FAIL taken_bubble: got %h/%h/%b want 0/%h/0", if_id_pc, if_id_instr, if_id_valid, NOP); end
        idle(1'b1);
        n_cmp++; if ({if_id_pc, if_id_instr, if_id_valid} !== {32'h100, tag(32'h100), 1'b1}) begin n_bad++;
            $display("FAIL taken_ifid: got %h/%h/%b want 100/%h/1", if_id_pc, if_id_instr, if_id_valid, tag(32'h100)); end
    endtask

    task automatic test_wrap;
        cyc(1'b1, 1'b0, 32'h0BAD_0000, 32'hFFFF_FFFC, 1'b0, 1'b1);
        idle(1'b1);
        n_cmp++; if ({imem_req, imem_addr} !== {1'b1, 32'd0}) begin n_bad++;
            $display("FAIL wrap_addr: got %b/%h want 1/0", imem_req, imem_addr); end
        idle(1'b1);
        n_cmp++; if ({if_id_pc, if_id_instr, if_id_valid} !== {32'd0, tag(32'd0), 1'b1}) begin n_bad++;
            $display("FAIL wrap_ifid: got %h/%h/%b want 0/%h/1", if_id_pc, if_id_instr, if_id_valid, tag(32'd0)); end
        cyc(1'b1, 1'b1, 32'h103, 32'd0, 1'b0, 1'b1);
        idle(1'b1);
        n_cmp++; if (imem_addr !== 32'h100) begin n_bad++; $display("FAIL align_addr: got %h want 100", imem_addr); end
        idle(1'b1);
        n_cmp++; if ({if_id_pc, if_id_valid} !== {32'h100, 1'b1}) begin n_bad++;
            $display("FAIL align_ifid: got %h/%b want 100/1", if_id_pc, if_id_valid); end
    endtask

    task automatic test_drop;
        cyc(1'b1, 1'b1, 32'h200, 32'd0, 1'b0, 1'b1);
        idle(1'b0);
        n_cmp++; if ({imem_req, imem_addr} !== {1'b1, 32'h200}) begin n_bad++;
            $display("FAIL drop_pre: got %b/%h want 1/200", imem_req, imem_addr); end
        cyc(1'b1, 1'b1, 32'h300, 32'd0, 1'b0, 1'b0);
        n_cmp++; if ({id_flush, imem_addr} !== {1'b1, 32'h200}) begin n_bad++;
            $display("FAIL drop_redirect: got fl=%b %h want 1 200", id_flush, imem_addr); end
        for (int w = 0; w < 2; w++) begin
            cyc(w == 0, 1'b1, 32'h300, 32'd0, 1'b0, 1'b0);
            n_cmp++; if ({imem_req, imem_addr, dbg_state} !== {1'b1, 32'h200, S_DROP}) begin n_bad++;
                $display("FAIL drop_wait%0d: got %b/%h st=%0d want 1/200 st=2", w, imem_req, imem_addr, dbg_state); end
            n_cmp++; if (if_id_valid !== 1'b0) begin n_bad++; $display("FAIL drop_valid%0d: got %b want 0", w, if_id_valid); end
        end
        idle(1'b1);
        n_cmp++; if ({imem_req, imem_addr, if_id_valid} !== {1'b1, 32'h200, 1'b0}) begin n_bad++;
            $display("FAIL drop_ready: got %b/%h v=%b want 1/200 v=0", imem_req, imem_addr, if_id_valid); end
        idle(1'b1);
        n_cmp++; if ({imem_addr, if_id_instr, if_id_valid} !== {32'h300, NOP, 1'b0}) begin n_bad++;
            $display("FAIL drop_discard: got %h/%h/%b want 300/%h/0", imem_addr, if_id_instr, if_id_valid, NOP); end
        idle(1'b1);
        n_cmp++; if ({if_id_pc, if_id_instr, if_id_valid} !== {32'h300, tag(32'h300), 1'b1}) begin n_bad++;
            $display("FAIL drop_target: got %h/%h/%b want 300/%h/1", if_id_pc, if_id_instr, if_id_valid, tag(32'h300)); end
    endtask

    task automatic test_hold;
        apply_reset();
        idle(1'b1);
        idle(1'b1);
        n_cmp++; if ({imem_addr, if_id_pc} !== {32'd4, 32'd0}) begin n_bad++;
            $display("FAIL hold_pre: got %h/%h want 4/0", imem_addr, if_id_pc); end
        cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        n_cmp++; if ({imem_req, imem_addr, if_id_pc} !== {1'b1, 32'd8, 32'd4}) begin n_bad++;
            $display("FAIL hold_accept: got %b/%h pc=%h want 1/8 pc=4", imem_req, imem_addr, if_id_pc); end
        for (int c = 0; c < 3; c++) begin
            cyc(1'b0, 1'b0, 32'd0, 32'd0, c < 2, 1'b0);
            n_cmp++; if ({imem_req, dbg_state} !== {1'b0, S_HOLD}) begin n_bad++;
                $display("FAIL hold_state%0d: got req=%b st=%0d want 0/3", c, imem_req, dbg_state); end
            n_cmp++; if ({if_id_pc, if_id_instr, if_id_valid} !== {32'd4, tag(32'd4), 1'b1}) begin n_bad++;
                $display("FAIL hold_frozen%0d: got %h/%h/%b want 4/%h/1", c, if_id_pc, if_id_instr, if_id_valid, tag(32'd4)); end
        end
        idle(1'b1);
        n_cmp++; if ({imem_req, imem_addr} !== {1'b1, 32'd12}) begin n_bad++;
            $display("FAIL hold_resume_addr: got %b/%h want 1/c", imem_req, imem_addr); end
        n_cmp++; if ({if_id_pc, if_id_instr, if_id_valid} !== {32'd8, tag(32'd8), 1'b1}) begin n_bad++;
            $display("FAIL hold_skid: got %h/%h/%b want 8/%h/1", if_id_pc, if_id_instr, if_id_valid, tag(32'd8)); end
        idle(1'b1);
        n_cmp++; if ({if_id_pc, if_id_instr} !== {32'd12, tag(32'd12)}) begin n_bad++;
            $display("FAIL hold_next: got %h/%h want c/%h", if_id_pc, if_id_instr, tag(32'd12)); end
    endtask

    task automatic test_reset_mid_drop;
        cyc(1'b1, 1'b1, 32'h400, 32'd0, 1'b0, 1'b0);
        idle(1'b0);
        n_cmp++; if (dbg_state !== S_DROP) begin n_bad++; $display("FAIL mid_drop_enter: got %0d want 2", dbg_state); end
        #2; rst_n = 1'b0; bran_stall = 1'b1; #1;
        n_cmp++; if ({imem_req, id_flush, dbg_state} !== {1'b0, 1'b0, S_BOOT}) begin n_bad++;
            $display("FAIL mid_drop_async: got req=%b fl=%b st=%0d want 0 0 0", imem_req, id_flush, dbg_state); end
        n_cmp++; if ({if_id_pc, if_id_instr, if_id_valid} !== {32'd0, NOP, 1'b0}) begin n_bad++;
            $display("FAIL mid_drop_ifid: got %h/%h/%b want 0/%h/0", if_id_pc, if_id_instr, if_id_valid, NOP); end
        @(negedge clk);
        do_release();
        n_cmp++; if ({imem_req, dbg_state} !== {1'b0, S_BOOT}) begin n_bad++;
            $display("FAIL mid_drop_boot: got req=%b st=%0d want 0/0", imem_req, dbg_state); end
        idle(1'b1);
        n_cmp++; if ({imem_req, imem_addr} !== {1'b1, 32'd0}) begin n_bad++;
            $display("FAIL mid_drop_refetch: got %b/%h want 1/0", imem_req, imem_addr); end
    endtask

    task automatic test_random;
        bit          b, bt, h, r, e_req, pb;
        logic [31:0] tgt, expc, e_addr;
        rand_data = 1'b1;
        apply_reset();
        model_reset();
        model_step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        pb = 1'b0; bt = 1'b0; tgt = 32'd0; expc = 32'd0;
        for (int i = 0; i < 3000; i++) begin
            e_req  = !m_boot && !m_skid_full;
            e_addr = m_stale_pend ? m_stale : m_pc;
            if (pb && ($urandom_range(0, 1) == 1)) begin
                b = 1'b1;
            end else begin
                b    = ($urandom_range(0, 7) == 0);
                bt   = $urandom_range(0, 1);
                tgt  = $urandom;
                expc = $urandom & 32'hFFFF_FFFC;
                if ($urandom_range(0, 15) == 0) expc = 32'hFFFF_FFFC;
            end
            h = ($urandom_range(0, 3) == 0);
            r = e_req && ($urandom_range(0, 2) != 0);
            cyc(b, bt, tgt, expc, h, r);
            n_cmp++; if ({imem_req, imem_addr} !== {e_req, e_addr}) begin n_bad++;
                $display("FAIL rnd_req%0d: got %b/%h want %b/%h", i, imem_req, imem_addr, e_req, e_addr); end
            n_cmp++; if (id_flush !== b) begin n_bad++; $display("FAIL rnd_flush%0d: got %b want %b", i, id_flush, b); end
            n_cmp++; if ({if_id_pc, if_id_instr, if_id_valid} !== {m_if_pc, m_if_instr, m_if_valid}) begin n_bad++;
                $display("FAIL rnd_ifid%0d: got %h/%h/%b want %h/%h/%b", i, if_id_pc, if_id_instr, if_id_valid,
                         m_if_pc, m_if_instr, m_if_valid); end
            model_step(b, bt, tgt, expc, h, r, imem_rdata);
            pb = b;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_startup();
        test_taken_branch();
        test_wrap();
        test_drop();
        test_hold();
        test_reset_mid_drop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
